// File: rtl/read_resp_xbar_if.sv
// Response bundle between the 4 cache channels, the return crossbar and the read requesters.
interface read_resp_xbar_if #(
  parameter int R_REQ_NUM = 8,
  parameter int DATA_W    = 512,
  parameter int TXNID_W   = 16,
  parameter int SB_W      = 8
);
  logic [3:0]                         in_vld;
  logic [3:0][DATA_W-1:0]             in_data;
  logic [3:0][TXNID_W-1:0]            in_txnid;
  logic [3:0][SB_W-1:0]               in_sideband;
  logic [3:0]                         in_last;
  logic [3:0]                         in_rdy;

  logic [R_REQ_NUM-1:0]               rd_resp_vld;
  logic [R_REQ_NUM-1:0][DATA_W-1:0]   rd_resp_data;
  logic [R_REQ_NUM-1:0][TXNID_W-1:0]  rd_resp_txnid;
  logic [R_REQ_NUM-1:0][SB_W-1:0]     rd_resp_sideband;
  logic [R_REQ_NUM-1:0]               rd_resp_last;
  logic [R_REQ_NUM-1:0]               rd_resp_rdy;

  modport slave (
    input  in_vld, in_data, in_txnid, in_sideband, in_last,
    output in_rdy,
    output rd_resp_vld, rd_resp_data, rd_resp_txnid, rd_resp_sideband, rd_resp_last,
    input  rd_resp_rdy
  );

  modport master (
    output in_vld, in_data, in_txnid, in_sideband, in_last,
    input  in_rdy,
    input  rd_resp_vld, rd_resp_data, rd_resp_txnid, rd_resp_sideband, rd_resp_last,
    output rd_resp_rdy
  );
endinterface

// File: rtl/read_resp_xbar.sv
// Read-response return crossbar: 4 cache channels to R_REQ_NUM requesters, per-output
// round-robin with burst lock, and a registered 2-entry skid buffer on every output.
module read_resp_xbar #(
  parameter int  R_REQ_NUM = 8,
  parameter int  DATA_W    = 512,
  parameter int  TXNID_W   = 16,
  parameter int  SB_W      = 8,
  localparam int ID_W      = $clog2(R_REQ_NUM)
) (
  input  logic            clk,
  input  logic            rst,
  read_resp_xbar_if.slave bus,
  output logic            err_bad_dest
);
  localparam int PW = DATA_W + TXNID_W + SB_W + 1;

  logic [3:0][ID_W-1:0]          w_dest;
  logic [3:0]                    w_bad;
  logic [3:0][PW-1:0]            w_ch_pay;
  logic [R_REQ_NUM-1:0][3:0]     w_req;
  logic [R_REQ_NUM-1:0][3:0]     w_gnt;
  logic [R_REQ_NUM-1:0][1:0]     w_gnt_ch;
  logic [R_REQ_NUM-1:0]          w_space;
  logic [R_REQ_NUM-1:0]          w_acc;
  logic [R_REQ_NUM-1:0]          w_deq;
  logic [R_REQ_NUM-1:0][PW-1:0]  w_in_pay;

  logic [R_REQ_NUM-1:0]          r_lock;
  logic [R_REQ_NUM-1:0][1:0]     r_lock_ch;
  logic [R_REQ_NUM-1:0][1:0]     r_ptr;
  logic [R_REQ_NUM-1:0][1:0]     r_cnt;
  logic [R_REQ_NUM-1:0][PW-1:0]  r_head;
  logic [R_REQ_NUM-1:0][PW-1:0]  r_tail;
  logic                          r_err;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_dest[i]   = bus.in_txnid[i][TXNID_W-1 -: ID_W];
      w_bad[i]    = bus.in_vld[i] & (int'(w_dest[i]) >= R_REQ_NUM);
      w_ch_pay[i] = {bus.in_data[i], bus.in_txnid[i], bus.in_sideband[i], bus.in_last[i]};
    end
  end

  // Descending scan so the channel closest to r_ptr is the last (winning) assignment.
  always_comb begin
    logic [1:0] w_c;
    w_c      = '0;
    w_req    = '0;
    w_gnt    = '0;
    w_gnt_ch = '0;
    w_space  = '0;
    w_acc    = '0;
    w_deq    = '0;
    w_in_pay = '0;
    for (int j = 0; j < R_REQ_NUM; j++) begin
      for (int i = 0; i < 4; i++) begin
        w_req[j][i] = bus.in_vld[i] & ~w_bad[i] & (int'(w_dest[i]) == j);
      end
      if (r_lock[j]) begin
        w_gnt_ch[j] = r_lock_ch[j];
      end else begin
        for (int k = 3; k >= 0; k--) begin
          w_c = r_ptr[j] + 2'(k);
          if (w_req[j][w_c]) w_gnt_ch[j] = w_c;
        end
      end
      w_gnt[j][w_gnt_ch[j]] = w_req[j][w_gnt_ch[j]];
      w_space[j]  = (r_cnt[j] != 2'd2);
      w_acc[j]    = (|w_gnt[j]) & w_space[j];
      w_deq[j]    = (r_cnt[j] != 2'd0) & bus.rd_resp_rdy[j];
      w_in_pay[j] = w_ch_pay[w_gnt_ch[j]];
    end
  end

  always_comb begin
    bus.in_rdy = w_bad;
    for (int j = 0; j < R_REQ_NUM; j++) begin
      for (int i = 0; i < 4; i++) begin
        bus.in_rdy[i] = bus.in_rdy[i] | (w_gnt[j][i] & w_space[j]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lock    <= '0;
      r_lock_ch <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_head    <= '0;
      r_tail    <= '0;
      r_err     <= 1'b0;
    end else begin
      if (|w_bad) r_err <= 1'b1;
      for (int j = 0; j < R_REQ_NUM; j++) begin
        if (w_acc[j]) begin
          if (w_in_pay[j][0]) begin
            r_lock[j] <= 1'b0;
            r_ptr[j]  <= w_gnt_ch[j] + 2'd1;
          end else begin
            r_lock[j]    <= 1'b1;
            r_lock_ch[j] <= w_gnt_ch[j];
          end
        end
        // Head is the presented beat; tail only holds a second beat while head is stalled.
        case ({w_acc[j], w_deq[j]})
          2'b10: begin
            if (r_cnt[j] == 2'd0) r_head[j] <= w_in_pay[j];
            else                  r_tail[j] <= w_in_pay[j];
            r_cnt[j] <= r_cnt[j] + 2'd1;
          end
          2'b01: begin
            r_head[j] <= r_tail[j];
            r_cnt[j]  <= r_cnt[j] - 2'd1;
          end
          2'b11: begin
            if (r_cnt[j] == 2'd1) begin
              r_head[j] <= w_in_pay[j];
            end else begin
              r_head[j] <= r_tail[j];
              r_tail[j] <= w_in_pay[j];
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    for (int j = 0; j < R_REQ_NUM; j++) begin
      bus.rd_resp_vld[j] = (r_cnt[j] != 2'd0);
      {bus.rd_resp_data[j], bus.rd_resp_txnid[j], bus.rd_resp_sideband[j],
       bus.rd_resp_last[j]} = r_head[j];
    end
  end

  assign err_bad_dest = r_err;
endmodule
